// File: rtl/phase_freq_detector.sv
`default_nettype none
// ============================================================================
// Module   : phase_freq_detector
// Purpose  : Signed edge-to-edge time difference, in fpga_clk_i cycles,
//            between the reference and generated clocks. It has input
//            synchronisers, a saturating result, cycle-slip and lock
//            reporting.
// Revision : 1.0 - initial release
// ============================================================================
module phase_freq_detector #(
    parameter int WIDTH       = 20,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_THRESH = 4,
    parameter int LOCK_COUNT  = 16
) (
    input  logic             fpga_clk_i,
    input  logic             reset_i,
    input  logic             reference_i,
    input  logic             generated_i,
    output logic [WIDTH-1:0] pd_error_o,
    output logic             pd_valid_o,
    output logic             slip_o,
    output logic             lock_o
);

    // The magnitude counter is one bit narrower than the result, so the
    // signed result is symmetric and never reaches the most negative code.
    localparam int             MW          = WIDTH - 1;
    localparam logic [MW-1:0]  c_mag_max   = {MW{1'b1}};
    localparam logic [MW-1:0]  c_mag_one   = MW'(1);
    localparam logic [MW-1:0]  c_thresh    = (LOCK_THRESH >= (2 ** MW)) ? c_mag_max : MW'(LOCK_THRESH);
    localparam int             LCW         = $clog2(LOCK_COUNT + 1);
    localparam logic [LCW-1:0] c_lock_max  = LCW'(LOCK_COUNT);
    localparam logic [LCW-1:0] c_lock_one  = LCW'(1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_REF_LEAD = 2'd1,
        S_GEN_LEAD = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] r_ref_sync;
    logic [SYNC_STAGES-1:0] r_gen_sync;
    logic                   r_ref_dly;
    logic                   r_gen_dly;
    logic                   w_ref_e;
    logic                   w_gen_e;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [MW-1:0]          r_cnt;
    logic [MW-1:0]          w_cnt_nxt;
    logic [MW-1:0]          w_cnt_inc;

    logic                   w_pub;
    logic                   w_pub_neg;
    logic [MW-1:0]          w_pub_mag;
    logic [WIDTH-1:0]       w_pub_pos;
    logic [WIDTH-1:0]       w_pub_err;
    logic                   w_slip;

    logic [LCW-1:0]         r_lock_cnt;
    logic [LCW-1:0]         w_lock_cnt_nxt;

    logic [WIDTH-1:0]       r_pd_error;
    logic                   r_pd_valid;
    logic                   r_slip;
    logic                   r_lock;

    // Synchronise both asynchronous inputs and keep a delayed copy of the last stage for edge detection.
    always_ff @(posedge fpga_clk_i) begin
        if (reset_i) begin
            r_ref_sync <= '0;
            r_gen_sync <= '0;
            r_ref_dly  <= 1'b0;
            r_gen_dly  <= 1'b0;
        end else begin
            r_ref_sync <= {r_ref_sync[SYNC_STAGES-2:0], reference_i};
            r_gen_sync <= {r_gen_sync[SYNC_STAGES-2:0], generated_i};
            r_ref_dly  <= r_ref_sync[SYNC_STAGES-1];
            r_gen_dly  <= r_gen_sync[SYNC_STAGES-1];
        end
    end

    assign w_ref_e   = r_ref_sync[SYNC_STAGES-1] & ~r_ref_dly;
    assign w_gen_e   = r_gen_sync[SYNC_STAGES-1] & ~r_gen_dly;
    assign w_cnt_inc = (r_cnt == c_mag_max) ? r_cnt : (r_cnt + c_mag_one);

    // State and lead counter registers.
    always_ff @(posedge fpga_clk_i) begin
        if (reset_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state, next count, and publish/slip decisions from the two edge events.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pub       = 1'b0;
        w_pub_neg   = 1'b0;
        w_pub_mag   = r_cnt;
        w_slip      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (w_ref_e && w_gen_e) begin
                    w_pub     = 1'b1;
                    w_pub_mag = '0;
                end else if (w_ref_e) begin
                    w_state_nxt = S_REF_LEAD;
                    w_cnt_nxt   = c_mag_one;
                end else if (w_gen_e) begin
                    w_state_nxt = S_GEN_LEAD;
                    w_cnt_nxt   = c_mag_one;
                end
            end
            S_REF_LEAD: begin
                if (w_gen_e) begin
                    w_pub = 1'b1;
                    // A coincident new reference edge opens the next measurement at once.
                    if (w_ref_e) begin
                        w_cnt_nxt = c_mag_one;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = '0;
                    end
                end else if (w_ref_e) begin
                    w_slip    = 1'b1;
                    w_cnt_nxt = c_mag_one;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            S_GEN_LEAD: begin
                w_pub_neg = 1'b1;
                if (w_ref_e) begin
                    w_pub = 1'b1;
                    if (w_gen_e) begin
                        w_cnt_nxt = c_mag_one;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = '0;
                    end
                end else if (w_gen_e) begin
                    w_slip    = 1'b1;
                    w_cnt_nxt = c_mag_one;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign w_pub_pos = {1'b0, w_pub_mag};
    assign w_pub_err = w_pub_neg ? ('0 - w_pub_pos) : w_pub_pos;

    // Run length of consecutive in-threshold results; any slip or large error restarts it.
    always_comb begin
        w_lock_cnt_nxt = r_lock_cnt;
        if (w_slip) begin
            w_lock_cnt_nxt = '0;
        end else if (w_pub) begin
            if (w_pub_mag <= c_thresh) begin
                w_lock_cnt_nxt = (r_lock_cnt == c_lock_max) ? r_lock_cnt : (r_lock_cnt + c_lock_one);
            end else begin
                w_lock_cnt_nxt = '0;
            end
        end
    end

    // Output registers; lock follows the run counter in the same cycle as the strobe.
    always_ff @(posedge fpga_clk_i) begin
        if (reset_i) begin
            r_pd_error <= '0;
            r_pd_valid <= 1'b0;
            r_slip     <= 1'b0;
            r_lock_cnt <= '0;
            r_lock     <= 1'b0;
        end else begin
            if (w_pub) begin
                r_pd_error <= w_pub_err;
            end
            r_pd_valid <= w_pub;
            r_slip     <= w_slip;
            r_lock_cnt <= w_lock_cnt_nxt;
            r_lock     <= (w_lock_cnt_nxt == c_lock_max);
        end
    end

    assign pd_error_o = r_pd_error;
    assign pd_valid_o = r_pd_valid;
    assign slip_o     = r_slip;
    assign lock_o     = r_lock;

endmodule
`default_nettype wire

// File: tb/tb_phase_freq_detector.sv
`default_nettype none
// ============================================================================
// Module   : tb_phase_freq_detector
// Purpose  : Directed self-checking bench for phase_freq_detector, with a
//            WIDTH=20 instance and a WIDTH=6 instance sharing the stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_phase_freq_detector;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        reference_i;
    logic        generated_i;
    logic [19:0] pd_error_o;
    logic        pd_valid_o;
    logic        slip_o;
    logic        lock_o;
    logic [5:0]  pd_error_s;
    logic        pd_valid_s;
    logic        slip_s;
    logic        lock_s;

    int n_checks = 0;
    int n_fail   = 0;

    phase_freq_detector #(.WIDTH(20)) dut (
        .fpga_clk_i  (clk),
        .reset_i     (reset_i),
        .reference_i (reference_i),
        .generated_i (generated_i),
        .pd_error_o  (pd_error_o),
        .pd_valid_o  (pd_valid_o),
        .slip_o      (slip_o),
        .lock_o      (lock_o)
    );

    phase_freq_detector #(.WIDTH(6)) dut_s (
        .fpga_clk_i  (clk),
        .reset_i     (reset_i),
        .reference_i (reference_i),
        .generated_i (generated_i),
        .pd_error_o  (pd_error_s),
        .pd_valid_o  (pd_valid_s),
        .slip_o      (slip_s),
        .lock_o      (lock_s)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    ro;
        int    go;
        int    exp_err;
        int    exp_err_s;
        int    exp_vc;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // Raise reference at iteration ro and generated at iteration go, then observe.
    task automatic run_meas(input int ro, input int go, output int nv, output int ev,
                            output int es, output int vc, output int ns, output int lk);
        int last;
        last = ((ro > go) ? ro : go) + 8;
        nv = 0; ev = 0; es = 0; vc = -1; ns = 0; lk = 0;
        for (int c = 0; c <= last; c++) begin
            reference_i = (c >= ro);
            generated_i = (c >= go);
            tick();
            if (pd_valid_o) begin
                nv++;
                ev = $signed(pd_error_o);
                vc = c;
                lk = int'(lock_o);
            end
            if (pd_valid_s) es = $signed(pd_error_s);
            if (slip_o) ns++;
        end
        reference_i = 1'b0;
        generated_i = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        int nv, ev, es, vc, ns, lk;
        int ns_s, lock_seen, nslip_idx;
        int slip_at[4];
        int lk_err[4];
        int lk_ro[4];
        int lk_go[4];

        vecs[0] = '{"ref_lead10",     0,  10,  10,  10, 12};
        vecs[1] = '{"gen_lead7",      7,   0,  -7,  -7,  9};
        vecs[2] = '{"simultaneous",   3,   3,   0,   0,  5};
        vecs[3] = '{"ref_lead1",      0,   1,   1,   1,  3};
        vecs[4] = '{"gen_lead1",      1,   0,  -1,  -1,  3};
        vecs[5] = '{"ref_lead40_sat", 0,  40,  40,  31, 42};

        lk_ro  = '{0, 4, 2, 0};
        lk_go  = '{4, 0, 2, 1};
        lk_err = '{4, -4, 0, 1};

        // Reset state
        reset_i = 1'b1; reference_i = 1'b0; generated_i = 1'b0;
        repeat (3) tick();
        check("rst.pd_error", int'(pd_error_o), 0);
        check("rst.pd_valid", int'(pd_valid_o), 0);
        check("rst.slip",     int'(slip_o), 0);
        check("rst.lock",     int'(lock_o), 0);
        reset_i = 1'b0;
        repeat (3) tick();

        // Table-driven single measurements
        for (int i = 0; i < 6; i++) begin
            run_meas(vecs[i].ro, vecs[i].go, nv, ev, es, vc, ns, lk);
            check($sformatf("%s.nvalid", vecs[i].name), nv, 1);
            check($sformatf("%s.err", vecs[i].name), ev, vecs[i].exp_err);
            check($sformatf("%s.err_w6", vecs[i].name), es, vecs[i].exp_err_s);
            check($sformatf("%s.valid_cycle", vecs[i].name), vc, vecs[i].exp_vc);
            check($sformatf("%s.slips", vecs[i].name), ns, 0);
            if (i == 1) check("gen_lead7.raw_hold", int'(pd_error_o), 32'h000FFFF9);
        end

        // Lock acquisition over 16 in-threshold results, then loss on +5
        reset_i = 1'b1; tick(); reset_i = 1'b0; tick();
        for (int i = 0; i < 16; i++) begin
            run_meas(lk_ro[i % 4], lk_go[i % 4], nv, ev, es, vc, ns, lk);
            check($sformatf("lock_run%0d.err", i), ev, lk_err[i % 4]);
            check($sformatf("lock_run%0d.lock", i), lk, (i == 15) ? 1 : 0);
        end
        check("lock.held_after_run", int'(lock_o), 1);
        run_meas(0, 5, nv, ev, es, vc, ns, lk);
        check("lock_break.err", ev, 5);
        check("lock_break.lock", lk, 0);

        // Reference period 50 with generated stalled, then generated 40 cycles after last reference edge
        ns = 0; ns_s = 0; nv = 0; lock_seen = 0; nslip_idx = 0; ev = 0; es = 0;
        for (int c = 0; c < 196; c++) begin
            reference_i = ((c % 50) < 25);
            generated_i = (c >= 190);
            tick();
            if (slip_o) begin
                ns++;
                if (nslip_idx < 4) slip_at[nslip_idx] = c;
                nslip_idx++;
            end
            if (slip_s) ns_s++;
            if (lock_o) lock_seen = 1;
            if (pd_valid_o) begin nv++; ev = $signed(pd_error_o); end
            if (pd_valid_s) es = $signed(pd_error_s);
        end
        reference_i = 1'b0; generated_i = 1'b0;
        repeat (4) tick();
        check("slip.count", ns, 3);
        check("slip.count_w6", ns_s, 3);
        check("slip.first_cycle", (nslip_idx > 0) ? slip_at[0] : -1, 52);
        check("slip.period", (nslip_idx > 1) ? (slip_at[1] - slip_at[0]) : -1, 50);
        check("slip.lock_low", lock_seen, 0);
        check("slip.lock_low_w6", int'(lock_s), 0);
        check("slip.nvalid", nv, 1);
        check("slip.err_lead40", ev, 40);
        check("slip.err_w6_sat", es, 31);

        // Reset in the middle of a reference-lead measurement
        nv = 0;
        reference_i = 1'b1; generated_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (pd_valid_o) nv++;
        end
        reference_i = 1'b0; reset_i = 1'b1;
        tick();
        check("midrst.pd_error", int'(pd_error_o), 0);
        repeat (2) tick();
        check("midrst.pd_valid", int'(pd_valid_o), 0);
        check("midrst.slip", int'(slip_o), 0);
        check("midrst.lock", int'(lock_o), 0);
        reset_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (pd_valid_o) nv++;
        end
        check("midrst.no_strobe", nv, 0);
        run_meas(6, 0, nv, ev, es, vc, ns, lk);
        check("postrst.nvalid", nv, 1);
        check("postrst.err_gen_lead", ev, -6);
        check("postrst.valid_cycle", vc, 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/phase_freq_detector.md
# phase_freq_detector

Parametrised successor to the ADPLL phase detector. It measures the signed time difference, in fpga_clk_i cycles, between matching rising edges of the reference and generated clocks. It adds internal input synchronisers, a two's-complement saturating result, a result-valid strobe, cycle-slip reporting and a lock indicator. It sits between the reference/DCO outputs and the loop filter, which consumes pd_error_o on each pd_valid_o.

## Interface
- WIDTH, 20: result/counter width, two's complement.
- SYNC_STAGES, 2: synchroniser flops per input, at least 2.
- LOCK_THRESH, 4: maximum |error| counted as in-lock.
- LOCK_COUNT, 16: consecutive in-lock results needed to assert lock_o, at least 1.

Ports (name, direction, width, meaning):
- fpga_clk_i, in, 1: sole clock, rising edge.
- reset_i, in, 1: synchronous, active-high reset.
- reference_i, in, 1: reference clock, asynchronous to fpga_clk_i.
- generated_i, in, 1: DCO output, asynchronous to fpga_clk_i.
- pd_error_o, out, WIDTH: signed phase error. Positive means reference leads.
- pd_valid_o, out, 1: one-cycle strobe; pd_error_o is new this cycle.
- slip_o, out, 1: one-cycle strobe; the leading input produced a second edge before the lagging one arrived.
- lock_o, out, 1: loop locked.

## Operation
- Each input passes through SYNC_STAGES flops. A rising edge is the last stage at 1 while its delayed copy is 0. The edge events are ref_e and gen_e.
- States are IDLE, REF_LEAD and GEN_LEAD. The counter is reset_i-cleared and is zero in IDLE.
- IDLE:
  - ref_e and gen_e together: publish 0, stay in IDLE.
  - ref_e alone: go to REF_LEAD with count=1.
  - gen_e alone: go to GEN_LEAD with count=1.
- REF_LEAD:
  - Each cycle without gen_e: count += 1, saturating at 2^(WIDTH-1)-1.
  - On gen_e: publish +count, return to IDLE, clear count.
  - ref_e without gen_e: pulse slip_o, restart count at 1, stay in REF_LEAD.
  - ref_e together with gen_e: publish +count, go to REF_LEAD with count=1. No slip.
- GEN_LEAD: mirror of REF_LEAD.
  - Publish -count.
  - Magnitude saturates at 2^(WIDTH-1)-1, so the result is symmetric and never -2^(WIDTH-1).
  - gen_e without ref_e is the slip case.
- Publish means: register pd_error_o and assert pd_valid_o for exactly one cycle.
- Lock:
  - A counter of consecutive published results with |error| <= LOCK_THRESH increments on each such result, saturating.
  - Any published result above the threshold, or any slip, clears the counter and deasserts lock_o in the next cycle.
  - lock_o = 1 once the counter reaches LOCK_COUNT.
- Reset values: pd_error_o=0, pd_valid_o=0, slip_o=0, lock_o=0. State is IDLE, all counters are 0, and the synchroniser and delay flops are 0.
  - An input held high through reset therefore produces one edge event after reset releases.
  - Reset mid-measurement discards the measurement with no strobe.

## Timing
- A rising edge first sampled high at clock n yields an edge event in cycle n+SYNC_STAGES.
- Latency from lagging edge event to result: the edge event is in cycle t, pd_valid_o is high in cycle t+1, and pd_error_o holds its value until the next publish.
- For ref_e in cycle t0 and gen_e in cycle t0+k (k at least 1), the result is +k. Equal-latency paths make the synchroniser depth cancel.
- slip_o is high in the cycle after the offending edge event.
- lock_o updates in the same cycle as the pd_valid_o that completes or breaks the run.
- Throughput: one result per lagging edge. Back-to-back results are allowed in consecutive cycles.

## Test plan
- Reference leads by 10 cycles: ref_e at t0, gen_e at t0+10 -> pd_valid_o at t0+11, pd_error_o=+10. No slip.
- Generated leads by 7 cycles -> pd_error_o=-7 (0xFFFF9 for WIDTH=20). One valid pulse.
- Simultaneous edges -> pd_error_o=0, valid one cycle after the edges, state stays IDLE.
- Reference period 50 cycles with generated stalled -> slip_o pulses every 50 cycles and lock_o=0. With WIDTH=6 and a 40-cycle lead, the result is +31 (saturated).
- 16 results within ±4 -> lock_o rises with the 16th pd_valid_o. A following result of +5 -> lock_o=0 the same cycle.
- Reset asserted 3 cycles after ref_e -> no pd_valid_o. A gen_e after reset releases starts GEN_LEAD, and every output reads 0 during reset.
